// File: rtl/wb_daq_pkg.sv
// Shared definitions for the wb_daq blocks: FSM encodings and status counter width.
package wb_daq_pkg;
  localparam int WORD_CNT_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'h0,
    ST_CAPTURE = 4'h1,
    ST_WRITE   = 4'h2,
    ST_DONE    = 4'h3
  } daq_state_e;
endpackage

// File: rtl/daq_sram_addr_gen.sv
// SRAM write-pointer for the DAQ writer: linear fill with sticky full flag,
// or ring-buffer wrap with sticky wrapped flag.
module daq_sram_addr_gen #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  wrap_en,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic                  buf_full,
  output logic                  wrapped
);

  always_ff @(posedge wb_clk) begin
    if (wb_rst || load) begin
      cur_addr <= base_addr;
      buf_full <= 1'b0;
      wrapped  <= 1'b0;
    end else if (advance) begin
      if (cur_addr == end_addr) begin
        // At the last word: wrap to base in ring mode, otherwise park and flag full
        if (wrap_en) begin
          cur_addr <= base_addr;
          wrapped  <= 1'b1;
        end else begin
          buf_full <= 1'b1;
        end
      end else begin
        cur_addr <= cur_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/daq_sram_writer.sv
// Moves one channel FIFO word at a time into SRAM through a
// capture / write / settle handshake, tracking fill status and word count.
module daq_sram_writer
  import wb_daq_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  enable,
  input  logic                  wrap_en,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic                  start_sram,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_done,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_data,
  input  logic                  sram_ack,
  output logic                  buf_full,
  output logic                  wrapped,
  output logic [WORD_CNT_W-1:0] word_count
);

  daq_state_e state_q, state_d;
  logic       clear_ok;
  logic       ack_ok;

  // Clear is honoured only when no transfer is in flight
  assign clear_ok = clear && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign ack_ok   = (state_q == ST_WRITE) && sram_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (enable && start_sram && !buf_full) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_WRITE;
      ST_WRITE:   if (sram_ack) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q      <= ST_IDLE;
      data_done    <= 1'b0;
      sram_wr_en   <= 1'b0;
      sram_wr_data <= '0;
      word_count   <= '0;
    end else begin
      state_q    <= state_d;
      data_done  <= (state_d == ST_CAPTURE);
      sram_wr_en <= (state_d == ST_WRITE);
      if ((state_q == ST_IDLE) && (state_d == ST_CAPTURE))
        sram_wr_data <= data_in;
      if (clear_ok)
        word_count <= '0;
      else if (ack_ok && (word_count != '1))
        word_count <= word_count + 1'b1;
    end
  end

  daq_sram_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .load      (clear_ok),
    .advance   (ack_ok),
    .wrap_en   (wrap_en),
    .base_addr (base_addr),
    .end_addr  (end_addr),
    .cur_addr  (sram_addr),
    .buf_full  (buf_full),
    .wrapped   (wrapped)
  );

endmodule

// File: tb/tb_daq_sram_writer.sv
// Directed + randomized bench for daq_sram_writer against a transaction-level model.
module tb_daq_sram_writer;
  import wb_daq_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          wb_clk = 1'b0;
  logic          wb_rst, enable, wrap_en, clear, start_sram, sram_ack;
  logic [AW-1:0] base_addr, end_addr, sram_addr;
  logic [DW-1:0] data_in, sram_wr_data;
  logic          data_done, sram_wr_en, buf_full, wrapped;
  logic [15:0]   word_count;

  int total = 0;
  int bad   = 0;

  // channel FIFO, SRAM ack model and observation logs
  logic [DW-1:0] fifo[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  int            wr_len_log[$];
  int            done_t[$];
  int            cyc = 0;
  int            ack_dly = 0;
  int            wr_n = 0;
  int            width_err = 0;
  int            unstable = 0;
  logic          prev_done = 1'b0;
  logic          wrap_seen = 1'b0;
  int            wrap_at = -1;
  logic [AW-1:0] a0;
  logic [DW-1:0] d0;

  daq_sram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .wb_clk       (wb_clk),
    .wb_rst       (wb_rst),
    .enable       (enable),
    .wrap_en      (wrap_en),
    .clear        (clear),
    .base_addr    (base_addr),
    .end_addr     (end_addr),
    .start_sram   (start_sram),
    .data_in      (data_in),
    .data_done    (data_done),
    .sram_wr_en   (sram_wr_en),
    .sram_addr    (sram_addr),
    .sram_wr_data (sram_wr_data),
    .sram_ack     (sram_ack),
    .buf_full     (buf_full),
    .wrapped      (wrapped),
    .word_count   (word_count)
  );

  always #5 wb_clk = ~wb_clk;
  always @(posedge wb_clk) cyc++;

  always @(negedge wb_clk) begin
    if (data_done) begin
      done_t.push_back(cyc);
      if (prev_done) width_err++;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    prev_done  = data_done;
    start_sram = (fifo.size() > 0);
    data_in    = (fifo.size() > 0) ? fifo[0] : '0;
    if (sram_wr_en) begin
      wr_n++;
      if (wr_n == 1) begin
        a0 = sram_addr;
        d0 = sram_wr_data;
      end else if (a0 !== sram_addr || d0 !== sram_wr_data) unstable++;
      sram_ack = (wr_n == ack_dly + 1);
      if (sram_ack) begin
        wr_addr_log.push_back(sram_addr);
        wr_data_log.push_back(sram_wr_data);
        wr_len_log.push_back(wr_n);
      end
    end else begin
      wr_n     = 0;
      sram_ack = 1'b0;
    end
    if (wrapped && !wrap_seen) begin
      wrap_seen = 1'b1;
      wrap_at   = int'(word_count);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_wr(input string tag);
    int t = 0;
    while (!sram_wr_en && t < 40) begin
      @(negedge wb_clk);
      t++;
    end
    chk({tag, "_wr_seen"}, 64'(t < 40), 64'd1);
  endtask

  // Quiesce, program bounds, clear, then stream n random words and compare
  // against the address/flag rules computed directly from base/end/wrap.
  task automatic run_phase(input string tag, input int base, input int lim, input bit wrp,
                           input int n, input int dly);
    logic [DW-1:0] words[$];
    int span, exp_wr, w;
    enable = 1'b0;
    repeat (12) @(negedge wb_clk);
    fifo.delete();
    base_addr = AW'(base);
    end_addr  = AW'(lim);
    wrap_en   = wrp;
    ack_dly   = dly;
    clear = 1'b1;
    @(negedge wb_clk);
    clear = 1'b0;
    chk({tag, "_clr_count"}, 64'(word_count), 64'd0);
    chk({tag, "_clr_full"},  64'(buf_full),   64'd0);
    chk({tag, "_clr_wrap"},  64'(wrapped),    64'd0);
    chk({tag, "_clr_addr"},  64'(sram_addr),  64'(base));
    wr_addr_log.delete(); wr_data_log.delete(); wr_len_log.delete(); done_t.delete();
    width_err = 0; unstable = 0; wrap_seen = 1'b0; wrap_at = -1;
    for (int i = 0; i < n; i++) begin
      w = int'($urandom());
      words.push_back(DW'(w));
      fifo.push_back(DW'(w));
    end
    enable = 1'b1;
    repeat (n * (dly + 4) + 20) @(negedge wb_clk);

    span   = lim - base + 1;
    exp_wr = wrp ? n : ((n < span) ? n : span);
    chk({tag, "_nwrites"}, 64'(wr_addr_log.size()), 64'(exp_wr));
    for (int i = 0; i < exp_wr && i < wr_addr_log.size(); i++) begin
      chk({tag, "_addr"}, 64'(wr_addr_log[i]), 64'(base + (wrp ? (i % span) : i)));
      chk({tag, "_data"}, 64'(wr_data_log[i]), 64'(words[i]));
      chk({tag, "_wrlen"}, 64'(wr_len_log[i]), 64'(dly + 1));
    end
    chk({tag, "_count"},   64'(word_count),     64'(exp_wr));
    chk({tag, "_full"},    64'(buf_full),       64'(!wrp && n >= span));
    chk({tag, "_wrapped"}, 64'(wrapped),        64'(wrp && n >= span));
    if (wrp && n >= span) chk({tag, "_wrap_at"}, 64'(wrap_at), 64'(span));
    chk({tag, "_ndone"},   64'(done_t.size()),  64'(exp_wr));
    chk({tag, "_left"},    64'(fifo.size()),    64'(n - exp_wr));
    for (int i = 1; i < done_t.size(); i++)
      chk({tag, "_gap"}, 64'(done_t[i] - done_t[i-1]), 64'(dly + 4));
    chk({tag, "_width"},  64'(width_err), 64'd0);
    chk({tag, "_stable"}, 64'(unstable),  64'd0);
  endtask

  initial begin
    int wc, b, s;
    wb_rst = 1'b1; enable = 1'b0; wrap_en = 1'b0; clear = 1'b0;
    base_addr = 10'h010; end_addr = 10'h013;
    start_sram = 1'b0; sram_ack = 1'b0; data_in = '0;
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    chk("rst_done",  64'(data_done),    64'd0);
    chk("rst_wren",  64'(sram_wr_en),   64'd0);
    chk("rst_wdata", 64'(sram_wr_data), 64'd0);
    chk("rst_full",  64'(buf_full),     64'd0);
    chk("rst_wrap",  64'(wrapped),      64'd0);
    chk("rst_count", 64'(word_count),   64'd0);
    chk("rst_addr",  64'(sram_addr),    64'h010);

    run_phase("nowrap", 'h010, 'h013, 1'b0, 5, 0);
    run_phase("wrap",   'h010, 'h013, 1'b1, 6, 0);

    // clear landing in WRITE must not disturb the transfer or the status
    ack_dly = 3;
    fifo.push_back(32'hC0FFEE01);
    wait_wr("clrw");
    clear = 1'b1;
    @(negedge wb_clk);
    clear = 1'b0;
    repeat (10) @(negedge wb_clk);
    chk("clrw_count", 64'(word_count), 64'd7);
    chk("clrw_wrap",  64'(wrapped),    64'd1);
    chk("clrw_addr",  64'(sram_addr),  64'h013);
    chk("clrw_data",  64'(wr_data_log[wr_data_log.size()-1]), 64'hC0FFEE01);

    run_phase("slowack", 'h010, 'h013, 1'b0, 3, 3);
    run_phase("single",  'h020, 'h020, 1'b1, 3, 0);
    run_phase("stream",  'h010, 'h013, 1'b1, 8, 0);

    // reset while a write is pending
    run_phase("prerst", 'h040, 'h047, 1'b0, 0, 0);
    ack_dly = 1000;
    fifo.push_back(32'h5A5A5A5A);
    wait_wr("rstw");
    wc = int'(word_count);
    wb_rst = 1'b1;
    @(posedge wb_clk);
    #1;
    chk("rstw_wren",  64'(sram_wr_en),  64'd0);
    chk("rstw_done",  64'(data_done),   64'd0);
    chk("rstw_count", 64'(word_count),  64'(wc));
    chk("rstw_addr",  64'(sram_addr),   64'h040);
    chk("rstw_state", 64'(dut.state_q), 64'(ST_IDLE));
    @(negedge wb_clk);
    wb_rst  = 1'b0;
    ack_dly = 0;

    for (int k = 0; k < 4; k++) begin
      b = int'($urandom_range(0, 1000));
      s = int'($urandom_range(1, 6));
      run_phase("rand", b, b + s - 1, 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 10)), int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
